// File: rtl/axi_quiesce_pkg.sv
// rtl/axi_quiesce_pkg.sv - shared types and helpers for the AXI quiesce sequencer
// Contents: qstate_t sequencer states, hs() handshake decode.
package axi_quiesce_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DRAIN  = 3'd1,
        GATE   = 3'd2,
        ISO    = 3'd3,
        UNGATE = 3'd4
    } qstate_t;

    function automatic logic hs(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/axi_quiesce_cnt.sv
// rtl/axi_quiesce_cnt.sv - outstanding-transaction up/down counter with zero flag
// Ports: clk_i, rst_i (sync, active-high), inc_i, dec_i, zero_o (count is zero).
module axi_quiesce_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (inc_i && !dec_i) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end else if (dec_i && !inc_i) begin
            count_q <= count_q - CNT_WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

    // Wrapping here means the master broke the AXI protocol; no RTL protection.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(inc_i && !dec_i && count_q == '1));
            assert (!(dec_i && !inc_i && count_q == '0));
        end
    end

endmodule

// File: rtl/axi_quiesce_ctrl.sv
// rtl/axi_quiesce_ctrl.sv - power-down sequencer for the dual-clock AXI master slice
// Optional feature macro: AXI_QUIESCE_TIMEOUT_EN (drain timeout and abort pulse).
// Ports: clk_i/rst_i (sync, active-high); sleep_req_i/sleep_ack_o/sleep_abort_o/wake_req_o
//        to the PMU; incoming_req_i/clock_down_o/isolate_o to the slice; idle_o;
//        aw/ar/w/r/b valid/ready (+ w/r last) handshake taps from the master side.
module axi_quiesce_ctrl
    import axi_quiesce_pkg::*;
#(
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sleep_req_i,
    output logic sleep_ack_o,
    output logic sleep_abort_o,
    output logic wake_req_o,
    input  logic incoming_req_i,
    output logic clock_down_o,
    output logic isolate_o,
    output logic idle_o,
    input  logic aw_valid_i,
    input  logic aw_ready_i,
    input  logic ar_valid_i,
    input  logic ar_ready_i,
    input  logic w_valid_i,
    input  logic w_ready_i,
    input  logic w_last_i,
    input  logic r_valid_i,
    input  logic r_ready_i,
    input  logic r_last_i,
    input  logic b_valid_i,
    input  logic b_ready_i
);

    localparam logic signed [CNT_WIDTH:0] W_MAX = {1'b0, {CNT_WIDTH{1'b1}}};
    localparam logic signed [CNT_WIDTH:0] W_MIN = {1'b1, {CNT_WIDTH{1'b0}}};

    qstate_t state_q, state_next;
    logic    clock_down_q, iso_q, wake_q;
    logic    wr_zero, rd_zero;
    logic    tmo_hit, start_ok;
    logic signed [CNT_WIDTH:0] w_bal_q;

    logic aw_hs, ar_hs, wl_hs, rl_hs, b_hs;
    assign aw_hs = hs(aw_valid_i, aw_ready_i);
    assign ar_hs = hs(ar_valid_i, ar_ready_i);
    assign wl_hs = hs(w_valid_i, w_ready_i) & w_last_i;
    assign rl_hs = hs(r_valid_i, r_ready_i) & r_last_i;
    assign b_hs  = hs(b_valid_i, b_ready_i);

    axi_quiesce_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_wr_out (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (aw_hs),
        .dec_i (b_hs),
        .zero_o(wr_zero)
    );

    axi_quiesce_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_rd_out (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ar_hs),
        .dec_i (rl_hs),
        .zero_o(rd_zero)
    );

    // Write-data balance: W may run ahead of AW, so this one is signed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_bal_q <= '0;
        end else if (aw_hs && !wl_hs) begin
            w_bal_q <= w_bal_q + (CNT_WIDTH + 1)'(1);
        end else if (wl_hs && !aw_hs) begin
            w_bal_q <= w_bal_q - (CNT_WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(aw_hs && !wl_hs && w_bal_q == W_MAX));
            assert (!(wl_hs && !aw_hs && w_bal_q == W_MIN));
        end
    end

    assign idle_o = wr_zero && rd_zero && (w_bal_q == '0);

    always_comb begin
        state_next = state_q;
        case (state_q)
            RUN:    if (sleep_req_i && start_ok) state_next = DRAIN;
            DRAIN: begin
                if (!sleep_req_i)           state_next = RUN;
                else if (w_bal_q == '0)     state_next = GATE;
            end
            GATE: begin
                // An AW taken on the gating edge leaves W owed; reopen the clock for it.
                if (!sleep_req_i)           state_next = UNGATE;
                else if (w_bal_q != '0)     state_next = DRAIN;
                else if (wr_zero && rd_zero) state_next = ISO;
            end
            ISO:    if (!sleep_req_i) state_next = UNGATE;
            UNGATE: state_next = RUN;
            default: state_next = RUN;
        endcase
        if (tmo_hit) state_next = UNGATE;
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            clock_down_q <= 1'b0;
            iso_q        <= 1'b0;
            wake_q       <= 1'b0;
        end else begin
            state_q      <= state_next;
            clock_down_q <= (state_next == GATE) || (state_next == ISO) || (state_next == UNGATE);
            iso_q        <= (state_next == ISO);
            wake_q       <= (state_next == ISO) && (wake_q || (state_q == ISO && incoming_req_i));
        end
    end

    assign clock_down_o = clock_down_q;
    assign isolate_o    = iso_q;
    assign sleep_ack_o  = iso_q;
    assign wake_req_o   = wake_q;

`ifdef AXI_QUIESCE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             blocked_q, abort_q;

    assign tmo_hit = ((state_q == DRAIN) || (state_q == GATE)) &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

    // After an abort, a still-high request must drop once before another attempt.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            blocked_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= ((state_next == DRAIN) || (state_next == GATE)) ?
                         tmo_cnt_q + TMO_W'(1) : '0;
            abort_q   <= tmo_hit;
            if (tmo_hit)          blocked_q <= 1'b1;
            else if (!sleep_req_i) blocked_q <= 1'b0;
        end
    end

    assign start_ok      = !blocked_q;
    assign sleep_abort_o = abort_q;
`else
    // Timeout parameter is meaningful only when the drain timeout is built in.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES == 0);
    assign tmo_hit        = 1'b0;
    assign start_ok       = 1'b1;
    assign sleep_abort_o  = 1'b0;
`endif

endmodule
